// File: rtl/dice_roll_qualifier_if.sv
// Roll qualifier bus: colour detector levels and game-controller handshake.
// The qualifier sits on the slave side and the stimulus/consumer side on the master side.
interface dice_roll_qualifier_if;
  logic       enable;
  logic       color_valid;
  logic [1:0] color_in;
  logic       white_in;
  logic       roll_ack;
  logic       roll_valid;
  logic [1:0] roll_value;
  logic [2:0] roll_steps;
  logic       armed;
  logic [7:0] roll_count;

  modport master (
    output enable, color_valid, color_in, white_in, roll_ack,
    input  roll_valid, roll_value, roll_steps, armed, roll_count
  );

  modport slave (
    input  enable, color_valid, color_in, white_in, roll_ack,
    output roll_valid, roll_value, roll_steps, armed, roll_count
  );
endinterface

// File: rtl/dice_roll_qualifier.sv
// Turns colour-detector levels into one qualified roll per throw (white -> dice -> steady -> handoff).
// Detector signals come from the pclk domain and are resynchronised into clk here.
module dice_roll_qualifier #(
  parameter int WHITE_CYCLES   = 1_000_000,
  parameter int CONFIRM_CYCLES = 5_000_000,
  parameter int CNT_W          = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  dice_roll_qualifier_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_WHITE = 3'd1,
    ST_ARMED      = 3'd2,
    ST_CONFIRM    = 3'd3,
    ST_OFFER      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] WHITE_LAST   = CNT_W'(WHITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  logic [1:0] cv_sync_q;
  logic [1:0] w_sync_q;
  logic [1:0] c_meta_q;
  logic [1:0] c_sync_q;
  logic       cv_s;
  logic       w_s;
  logic [1:0] c_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cand_q, cand_d;
  logic             roll_valid_q, roll_valid_d;
  logic [1:0]       roll_value_q, roll_value_d;
  logic [2:0]       roll_steps_q, roll_steps_d;
  logic             armed_q, armed_d;
  logic [7:0]       roll_count_q, roll_count_d;

  // Two-flop synchronisers for the pclk-domain detector levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cv_sync_q <= 2'b00;
      w_sync_q  <= 2'b00;
      c_meta_q  <= 2'b00;
      c_sync_q  <= 2'b00;
    end else begin
      cv_sync_q <= {cv_sync_q[0], bus.color_valid};
      w_sync_q  <= {w_sync_q[0], bus.white_in};
      c_meta_q  <= bus.color_in;
      c_sync_q  <= c_meta_q;
    end
  end

  assign cv_s = cv_sync_q[1];
  assign w_s  = w_sync_q[1];
  assign c_s  = c_sync_q;

  // State, dwell counter, candidate colour and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      cand_q       <= 2'b00;
      roll_valid_q <= 1'b0;
      roll_value_q <= 2'b00;
      roll_steps_q <= 3'b000;
      armed_q      <= 1'b0;
      roll_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      roll_valid_q <= roll_valid_d;
      roll_value_q <= roll_value_d;
      roll_steps_q <= roll_steps_d;
      armed_q      <= armed_d;
      roll_count_q <= roll_count_d;
    end
  end

  // Throw protocol next-state; disable overrides every state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    roll_valid_d = roll_valid_q;
    roll_value_d = roll_value_q;
    roll_steps_d = roll_steps_q;
    roll_count_d = roll_count_q;

    if (!bus.enable) begin
      state_d      = ST_IDLE;
      cnt_d        = CNT_ZERO;
      roll_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_WHITE;
          cnt_d   = CNT_ZERO;
        end
        ST_WAIT_WHITE: begin
          if (w_s) begin
            if (cnt_q == WHITE_LAST) begin
              state_d = ST_ARMED;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        ST_ARMED: begin
          if (!w_s && cv_s) begin
            state_d = ST_CONFIRM;
            cand_d  = c_s;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_CONFIRM: begin
          // Tray white again means the dice were lifted before qualifying.
          if (w_s) begin
            state_d = ST_ARMED;
            cnt_d   = CNT_ZERO;
          end else if (!cv_s || (c_s != cand_q)) begin
            cand_d = c_s;
            cnt_d  = CNT_ZERO;
          end else if (cnt_q == CONFIRM_LAST) begin
            state_d      = ST_OFFER;
            cnt_d        = CNT_ZERO;
            roll_valid_d = 1'b1;
            roll_value_d = cand_q;
            roll_steps_d = {1'b0, cand_q} + 3'd1;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        ST_OFFER: begin
          if (roll_valid_q && bus.roll_ack) begin
            state_d      = ST_WAIT_WHITE;
            cnt_d        = CNT_ZERO;
            roll_valid_d = 1'b0;
            roll_count_d = roll_count_q + 8'd1;
          end else begin
            state_d = ST_OFFER;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          cnt_d        = CNT_ZERO;
          roll_valid_d = 1'b0;
        end
      endcase
    end

    armed_d = (state_d == ST_ARMED) || (state_d == ST_CONFIRM);
  end

  assign bus.roll_valid = roll_valid_q;
  assign bus.roll_value = roll_value_q;
  assign bus.roll_steps = roll_steps_q;
  assign bus.armed      = armed_q;
  assign bus.roll_count = roll_count_q;

endmodule

// File: tb/tb_dice_roll_qualifier.sv
// Directed bench for dice_roll_qualifier with short dwell parameters (white 4, confirm 8).
module tb_dice_roll_qualifier;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  dice_roll_qualifier_if bus ();

  dice_roll_qualifier #(
    .WHITE_CYCLES  (4),
    .CONFIRM_CYCLES(8),
    .CNT_W         (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_roll(input string tag, input int limit);
    int n;
    n = 0;
    while (!bus.roll_valid && n < limit) begin
      tick(1);
      n++;
    end
    chk_val(tag, int'(bus.roll_valid), 1);
  endtask

  task automatic ack_once;
    bus.roll_ack = 1'b1;
    tick(1);
    bus.roll_ack = 1'b0;
  endtask

  // Full throw from WAIT_WHITE: white dwell, dice with colour c, wait for the offer.
  task automatic present_roll(input logic [1:0] c);
    bus.white_in    = 1'b1;
    bus.color_valid = 1'b0;
    tick(6);
    bus.white_in    = 1'b0;
    bus.color_valid = 1'b1;
    bus.color_in    = c;
    wait_roll("roll_offer", 20);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.enable      = 1'b0;
    bus.color_valid = 1'b0;
    bus.color_in    = 2'd0;
    bus.white_in    = 1'b0;
    bus.roll_ack    = 1'b0;
    tick(2);
    reset = 1'b1;

    // Idle with enable low
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk_val("idle_armed", int'(bus.armed), 0);
      chk_val("idle_valid", int'(bus.roll_valid), 0);
    end

    // One acked roll, then an offered roll killed by asynchronous reset
    bus.enable = 1'b1;
    present_roll(2'd3);
    chk_val("pre_value", int'(bus.roll_value), 3);
    chk_val("pre_steps", int'(bus.roll_steps), 4);
    ack_once();
    chk_val("pre_count", int'(bus.roll_count), 1);
    present_roll(2'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_val("rst_valid", int'(bus.roll_valid), 0);
    chk_val("rst_value", int'(bus.roll_value), 0);
    chk_val("rst_steps", int'(bus.roll_steps), 0);
    chk_val("rst_armed", int'(bus.armed), 0);
    chk_val("rst_count", int'(bus.roll_count), 0);
    bus.enable      = 1'b0;
    bus.color_valid = 1'b0;
    bus.color_in    = 2'd0;
    tick(1);
    reset = 1'b1;
    tick(2);

    // Nominal roll with exact cycle timing
    bus.enable   = 1'b1;
    bus.white_in = 1'b1;
    tick(5);
    chk_val("nom_armed_e5", int'(bus.armed), 0);
    tick(1);
    chk_val("nom_armed_e6", int'(bus.armed), 1);
    tick(4);
    bus.white_in    = 1'b0;
    bus.color_valid = 1'b1;
    bus.color_in    = 2'd2;
    tick(10);
    chk_val("nom_valid_e20", int'(bus.roll_valid), 0);
    chk_val("nom_armed_e20", int'(bus.armed), 1);
    tick(1);
    chk_val("nom_valid_e21", int'(bus.roll_valid), 1);
    chk_val("nom_value", int'(bus.roll_value), 2);
    chk_val("nom_steps", int'(bus.roll_steps), 3);
    chk_val("nom_armed_offer", int'(bus.armed), 0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_val("nom_hold", int'(bus.roll_valid), 1);
      chk_val("nom_hold_value", int'(bus.roll_value), 2);
    end
    ack_once();
    chk_val("nom_ack_valid", int'(bus.roll_valid), 0);
    chk_val("nom_count", int'(bus.roll_count), 1);

    // Dice left in place never re-rolls
    bus.color_in = 2'd1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk_val("norr_valid", int'(bus.roll_valid), 0);
    end
    bus.white_in = 1'b1;
    tick(6);
    chk_val("norr_armed", int'(bus.armed), 1);
    bus.white_in = 1'b0;
    bus.color_in = 2'd0;
    wait_roll("norr_offer", 20);
    chk_val("norr_steps", int'(bus.roll_steps), 1);
    ack_once();
    chk_val("norr_count", int'(bus.roll_count), 2);

    // Colour change mid-confirm restarts the dwell
    bus.white_in    = 1'b1;
    bus.color_valid = 1'b0;
    tick(6);
    bus.white_in    = 1'b0;
    bus.color_valid = 1'b1;
    bus.color_in    = 2'd1;
    tick(8);
    bus.color_in = 2'd3;
    for (int i = 15; i <= 24; i++) begin
      tick(1);
      chk_val("glitch_no_roll", int'(bus.roll_valid), 0);
    end
    tick(1);
    chk_val("glitch_roll_e25", int'(bus.roll_valid), 1);
    chk_val("glitch_value", int'(bus.roll_value), 3);
    ack_once();
    chk_val("glitch_count", int'(bus.roll_count), 3);

    // One-cycle white bounce in confirm drops back to armed
    bus.white_in    = 1'b1;
    bus.color_valid = 1'b0;
    tick(6);
    bus.white_in    = 1'b0;
    bus.color_valid = 1'b1;
    bus.color_in    = 2'd2;
    tick(5);
    bus.white_in = 1'b1;
    tick(1);
    bus.white_in = 1'b0;
    for (int i = 13; i <= 22; i++) begin
      tick(1);
      chk_val("bounce_no_roll", int'(bus.roll_valid), 0);
      if (i == 14) begin
        chk_val("bounce_armed", int'(bus.armed), 1);
      end
    end
    tick(1);
    chk_val("bounce_roll_e23", int'(bus.roll_valid), 1);
    ack_once();
    chk_val("bounce_count", int'(bus.roll_count), 4);

    // Abort an offer by dropping enable
    present_roll(2'd2);
    bus.enable = 1'b0;
    tick(1);
    chk_val("abort_valid", int'(bus.roll_valid), 0);
    chk_val("abort_armed", int'(bus.armed), 0);
    chk_val("abort_count", int'(bus.roll_count), 4);
    chk_val("abort_value", int'(bus.roll_value), 2);
    chk_val("abort_steps", int'(bus.roll_steps), 3);
    tick(3);
    bus.enable      = 1'b1;
    bus.white_in    = 1'b1;
    bus.color_valid = 1'b0;
    tick(5);
    chk_val("reen_armed_e5", int'(bus.armed), 0);
    tick(1);
    chk_val("reen_armed_e6", int'(bus.armed), 1);
    bus.white_in    = 1'b0;
    bus.color_valid = 1'b1;
    bus.color_in    = 2'd0;
    wait_roll("reen_offer", 20);
    ack_once();
    chk_val("reen_count", int'(bus.roll_count), 5);

    // Count wraps 255 -> 0
    for (int r = 5; r < 255; r++) begin
      present_roll(2'(r));
      ack_once();
    end
    chk_val("wrap_255", int'(bus.roll_count), 255);
    present_roll(2'd1);
    ack_once();
    chk_val("wrap_0", int'(bus.roll_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dice_roll_qualifier.md
Name: dice_roll_qualifier

Overview:
- Sits between Color_Detector (pclk domain) and Game_Logic_Controller (clk domain).
- Turns the detector's stable_color, result_ready and current_state_white levels into exactly one qualified roll per throw.
- Enforces a throw protocol: tray empty (white) → dice present → colour held steady → roll handed off with a valid/ack handshake → tray must show white again before the next roll.
- Also synchronises the detector signals into clk.

Parameters:
- WHITE_CYCLES, 1_000_000: consecutive clk cycles of white required to arm (10 ms at 100 MHz).
- CONFIRM_CYCLES, 5_000_000: consecutive clk cycles of an unchanged, valid, non-white colour required to qualify a roll.
- CNT_W, 23: width of the dwell counter; must hold max(WHITE_CYCLES, CONFIRM_CYCLES).

Ports:
- clk  in  1  system clock (same clk as Game_Logic_Controller).
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high while the system is in game state; low forces IDLE.
- color_valid  in  1  result_ready from Color_Detector, pclk domain (level).
- color_in  in  2  stable_color from Color_Detector, pclk domain.
- white_in  in  1  current_state_white from Color_Detector, pclk domain.
- roll_ack  in  1  consumer accepts the roll.
- roll_valid  out  1  a qualified roll is presented.
- roll_value  out  2  qualified colour code.
- roll_steps  out  3  roll_value + 1 (range 1..4).
- armed  out  1  high in ARMED and CONFIRM.
- roll_count  out  8  number of accepted rolls; wraps 255 → 0.

Behaviour:
- **Reset:** reset low clears all state asynchronously. State = IDLE, counter = 0, sync flops = 0. All outputs = 0.
- **Synchronisers:**
  - color_valid, white_in and each color_in bit pass through 2-flop synchronisers; the sampled copies are cv_s, w_s, c_s.
  - Input-to-sample latency is 2 cycles.
  - Multi-bit skew on color_in is tolerated because CONFIRM requires stability.
- **Dwell counter (cnt):** CNT_W-bit. Cleared on every state entry. Saturates; never wraps.
- **IDLE:** if enable → WAIT_WHITE.
- **WAIT_WHITE:**
  - w_s high: cnt++.
  - w_s low: cnt = 0.
  - When cnt == WHITE_CYCLES-1 with w_s high → ARMED.
- **ARMED:** when w_s low and cv_s high → CONFIRM; latch cand = c_s and set cnt = 0.
- **CONFIRM:**
  - w_s high → ARMED (dice removed before qualifying).
  - cv_s low or c_s != cand → cand = c_s, cnt = 0, stay in CONFIRM.
  - Otherwise cnt++.
  - When cnt == CONFIRM_CYCLES-1 with a matching sample → OFFER. On entry: roll_value = cand, roll_steps = cand + 1 (zero-extended 3-bit add), roll_valid = 1.
- **OFFER:**
  - roll_valid, roll_value and roll_steps are held stable until roll_ack.
  - Inputs are ignored in this state.
  - roll_valid & roll_ack in the same cycle → roll_valid = 0, roll_count++ (mod 256), next state WAIT_WHITE.
  - Transfer completes on the first cycle where both are high, including the first cycle of OFFER.
  - roll_ack while roll_valid is low is ignored.
- **enable low:** in any state, enable low → IDLE on the next edge. roll_valid = 0, armed = 0, cnt = 0. roll_value, roll_steps and roll_count keep their last values. An offered roll that was not acked is discarded and not counted.
- **Arming rule:** after a transfer, a new roll requires a full white dwell again. A dice left in place never produces a second roll.
- **Outputs:** all registered; no combinational path from any input to any output.

Test Plan (override WHITE_CYCLES=4, CONFIRM_CYCLES=8, CNT_W=4):
1. **Reset and idle.** Drive reset low mid-run with roll_valid high. Required: all outputs 0 immediately (asynchronous). After release with enable=0, the block stays in IDLE for 20 cycles and armed=0.
2. **Nominal roll.** enable=1, white_in=1 for 10 cycles, then white_in=0, color_valid=1, color_in=2, roll_ack=0.
   - Required: armed rises 2+4 cycles after white starts.
   - roll_valid rises 8 cycles after the colour is first sampled (2-cycle sync latency), with roll_value=2 and roll_steps=3.
   - roll_valid is held for 5 cycles.
   - Assert roll_ack for 1 cycle: roll_valid falls on the next edge and roll_count=1.
3. **Glitch and bounce.** In CONFIRM, switch color_in 1→3 after 5 cycles. Required: the counter restarts and roll_value=3 after 8 further stable cycles. A separate run that pulses white_in for 1 cycle in CONFIRM returns to armed with no roll.
4. **No re-roll.** After an acked roll, keep color_in=1, white_in=0 for 50 cycles. Required: roll_valid stays 0. Then white_in=1 for 4+2 cycles and remove it with colour 0: the next roll has roll_steps=1 and roll_count=2.
5. **Abort and wrap.** Drop enable while roll_valid=1. Required: roll_valid=0 next cycle, roll_count unchanged, and re-enable restarts from WAIT_WHITE. Separately, 256 acked rolls return roll_count to 0.
